gpio_bank_ip: RTL

- Parametrised successor to the single-register GPIO peripheral.
- Provides a WIDTH-bit GPIO bank with per-pin direction and atomic set/clear/toggle of outputs.
- Adds synchronised input sampling and rising-edge interrupt capture with a per-pin enable and a write-1-to-clear status register.
- Sits on the same simple wr_en/rd_en register bus as the existing GPIO block.

---
 rtl/gpio_bank_ip.sv | 137 +++++++++++++
 1 files changed

// File: rtl/gpio_bank_ip.sv
// gpio_bank_ip: WIDTH-bit GPIO bank on the simple wr_en/rd_en register bus.
// Per-pin direction, atomic set/clear/toggle of OUT, synchronised inputs and
// rising-edge interrupt capture with per-pin enable and W1C status.
//
// Register bus handshake: a write is accepted on every clk edge where wr_en=1;
// a read is accepted on every clk edge where rd_en=1, and its data appears on
// rdata with rdata_valid=1 during the following cycle. There is no
// back-pressure: the block is always ready.
module gpio_bank_ip #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [2:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             rdata_valid,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq,
    output logic             dbg_prime_state
);

    localparam int CW = $clog2(SYNC_STAGES + 1);

    // Prime counter states: PRIMING blocks edge capture just after reset.
    localparam logic [0:0] PRIMING = 1'b0;
    localparam logic [0:0] ARMED   = 1'b1;

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_SET  = 3'd3;
    localparam logic [2:0] A_CLR  = 3'd4;
    localparam logic [2:0] A_TGL  = 3'd5;
    localparam logic [2:0] A_IEN  = 3'd6;
    localparam logic [2:0] A_ISTS = 3'd7;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] ien_q, ien_d;
    logic [WIDTH-1:0] sts_q, sts_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] w1c;
    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [31:0]      rdata_q, rd_mux;
    logic             rvalid_q;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign wmask    = wdata[WIDTH-1:0];
    assign w1c      = (wr_en && addr == A_ISTS) ? wmask : '0;
    assign rise     = sync_out & ~prev_q & ~dir_q & {WIDTH{state_q == ARMED}};

    // Next-state for the software-visible registers and the prime counter.
    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        ien_d   = ien_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (wr_en) begin
            case (addr)
                A_OUT:   out_d = wmask;
                A_DIR:   dir_d = wmask;
                A_SET:   out_d = out_q | wmask;
                A_CLR:   out_d = out_q & ~wmask;
                A_TGL:   out_d = out_q ^ wmask;
                A_IEN:   ien_d = wmask;
                default: ;
            endcase
        end
        // Set has priority over a same-cycle W1C of the same bit.
        sts_d = (sts_q & ~w1c) | rise;
        if (state_q == PRIMING) begin
            if (cnt_q == CW'(SYNC_STAGES)) state_d = ARMED;
            else                           cnt_d   = cnt_q + 1'b1;
        end
    end

    // Read mux; values are taken before this cycle's write lands.
    always_comb begin
        rd_mux = '0;
        case (addr)
            A_OUT:   rd_mux[WIDTH-1:0] = out_q;
            A_DIR:   rd_mux[WIDTH-1:0] = dir_q;
            A_IN:    rd_mux[WIDTH-1:0] = sync_out;
            A_IEN:   rd_mux[WIDTH-1:0] = ien_q;
            A_ISTS:  rd_mux[WIDTH-1:0] = sts_q;
            default: rd_mux = '0;
        endcase
    end

    // All state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q    <= '0;
            dir_q    <= '0;
            ien_q    <= '0;
            sts_q    <= '0;
            prev_q   <= '0;
            state_q  <= PRIMING;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            ien_q    <= ien_d;
            sts_q    <= sts_d;
            prev_q   <= sync_out;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rd_en;
            if (rd_en) rdata_q <= rd_mux;
            sync_q[0] <= gpio_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign rdata           = rdata_q;
    assign rdata_valid     = rvalid_q;
    assign gpio_out        = out_q;
    assign gpio_oe         = dir_q;
    assign irq             = |(sts_q & ien_q);
    assign dbg_prime_state = state_q;

endmodule
